// File: rtl/scan_window_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_window_sequencer_pkg - pyramid geometry, pipeline depth, FSM states |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package scan_window_sequencer_pkg;

   localparam int N_PYR_LEVELS = 13;

   // Level 0 occupies the most-significant 32-bit field.
   localparam logic [N_PYR_LEVELS*32-1:0] PYRAMID_WIDTHS = {
      32'd320, 32'd266, 32'd222, 32'd185, 32'd154, 32'd128, 32'd107,
      32'd89,  32'd74,  32'd62,  32'd51,  32'd43,  32'd35
   };
   localparam logic [N_PYR_LEVELS*32-1:0] PYRAMID_HEIGHTS = {
      32'd240, 32'd200, 32'd166, 32'd139, 32'd116, 32'd96, 32'd80,
      32'd67,  32'd56,  32'd46,  32'd39,  32'd32,  32'd27
   };

   localparam int WIN_SIZE      = 24;
   localparam int VJ_PIPE_DEPTH = 2914;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_SETTLE = 3'd2,
      S_SCAN   = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_window_sequencer_raster.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_raster_counter - col/row/level nested window counter with last    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module window_raster_counter
   import scan_window_sequencer_pkg::*;
#(
   parameter int                         NUM_LEVELS = N_PYR_LEVELS,
   parameter logic [NUM_LEVELS*32-1:0]   LEVEL_W    = PYRAMID_WIDTHS,
   parameter logic [NUM_LEVELS*32-1:0]   LEVEL_H    = PYRAMID_HEIGHTS,
   parameter int                         WIN        = WIN_SIZE
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_load,
   input  logic        i_step,
   output logic [3:0]  o_img,
   output logic [31:0] o_row,
   output logic [31:0] o_col,
   output logic        o_last,
   output logic        o_any
);

   logic [3:0]            r_img;
   logic [31:0]           r_row;
   logic [31:0]           r_col;
   logic [NUM_LEVELS-1:0] w_ok;
   logic [31:0]           w_col_max_lvl [NUM_LEVELS];
   logic [31:0]           w_row_max_lvl [NUM_LEVELS];
   logic [31:0]           w_col_max;
   logic [31:0]           w_row_max;
   logic [3:0]            w_first;
   logic [3:0]            w_next;
   logic                  w_has_next;

   for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_level
      localparam int c_shift = (NUM_LEVELS - 1 - l) * 32;
      assign w_ok[l] = (LEVEL_W[c_shift +: 32] >= 32'(WIN)) &&
                       (LEVEL_H[c_shift +: 32] >= 32'(WIN));
      assign w_col_max_lvl[l] = LEVEL_W[c_shift +: 32] - 32'(WIN);
      assign w_row_max_lvl[l] = LEVEL_H[c_shift +: 32] - 32'(WIN);
   end

   // Descending scans let the lowest qualifying level win, so undersized levels are skipped.
   always_comb begin
      w_col_max  = '0;
      w_row_max  = '0;
      w_first    = '0;
      w_next     = '0;
      w_has_next = 1'b0;
      for (int l = 0; l < NUM_LEVELS; l++) begin
         if (r_img == 4'(l)) begin
            w_col_max = w_col_max_lvl[l];
            w_row_max = w_row_max_lvl[l];
         end
      end
      for (int l = NUM_LEVELS - 1; l >= 0; l--) begin
         if (w_ok[l]) begin
            w_first = 4'(l);
         end
         if (w_ok[l] && (4'(l) > r_img)) begin
            w_next     = 4'(l);
            w_has_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_img <= '0;
         r_row <= '0;
         r_col <= '0;
      end else if (i_load) begin
         r_img <= w_first;
         r_row <= '0;
         r_col <= '0;
      end else if (i_step) begin
         if (r_col < w_col_max) begin
            r_col <= r_col + 32'd1;
         end else begin
            r_col <= '0;
            if (r_row < w_row_max) begin
               r_row <= r_row + 32'd1;
            end else begin
               r_row <= '0;
               r_img <= w_has_next ? w_next : 4'd0;
            end
         end
      end
   end

   assign o_img  = r_img;
   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_last = (r_col >= w_col_max) && (r_row >= w_row_max) && !w_has_next;
   assign o_any  = |w_ok;

endmodule
`default_nettype wire

// File: rtl/scan_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_window_sequencer - frame sequencing FSM for the Viola-Jones path    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module scan_window_sequencer
   import scan_window_sequencer_pkg::*;
#(
   parameter int                         NUM_LEVELS    = N_PYR_LEVELS,
   parameter logic [NUM_LEVELS*32-1:0]   LEVEL_W       = PYRAMID_WIDTHS,
   parameter logic [NUM_LEVELS*32-1:0]   LEVEL_H       = PYRAMID_HEIGHTS,
   parameter int                         WIN           = WIN_SIZE,
   parameter int                         PIPE_DEPTH    = VJ_PIPE_DEPTH,
   parameter int                         SETTLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_hold,
   input  logic        i_face_coords_ready,
   output logic [3:0]  o_img_index,
   output logic [31:0] o_row_index,
   output logic [31:0] o_col_index,
   output logic        o_vj_enable,
   output logic        o_vj_reset,
   output logic        o_busy,
   output logic        o_frame_done,
   output logic        o_face_valid,
   output logic [15:0] o_face_count
);

   seq_state_t  r_state;
   seq_state_t  w_state_next;
   logic [15:0] r_settle;
   logic [31:0] r_issued;
   logic [31:0] r_retired;
   logic [31:0] r_fill;
   logic        r_retire_pend;
   logic        r_vj_enable;
   logic        r_vj_reset;
   logic        r_busy;
   logic        r_frame_done;
   logic [15:0] r_face_count;
   logic        w_en_next;
   logic        w_step;
   logic        w_retire;
   logic        w_accept;
   logic        w_load;
   logic        w_last;
   logic        w_any;
   logic [31:0] w_issued_next;
   logic [31:0] w_retired_next;

   window_raster_counter #(
      .NUM_LEVELS (NUM_LEVELS),
      .LEVEL_W    (LEVEL_W),
      .LEVEL_H    (LEVEL_H),
      .WIN        (WIN)
   ) u_raster (
      .clock  (clock),
      .reset  (reset),
      .i_load (w_load),
      .i_step (w_step),
      .o_img  (o_img_index),
      .o_row  (o_row_index),
      .o_col  (o_col_index),
      .o_last (w_last),
      .o_any  (w_any)
   );

   // The registered enable marks the cycle whose closing edge shifts the pipeline.
   assign w_accept       = (r_state == S_IDLE) && i_start;
   assign w_load         = (r_state == S_CLEAR);
   assign w_step         = (r_state == S_SCAN) && r_vj_enable;
   assign w_retire       = r_vj_enable && (r_fill == 32'(PIPE_DEPTH));
   assign w_issued_next  = r_issued + {31'd0, w_step};
   assign w_retired_next = r_retired + {31'd0, w_retire};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_en_next    = 1'b0;
      case (r_state)
         S_IDLE:   if (i_start) w_state_next = S_CLEAR;
         S_CLEAR:  w_state_next = S_SETTLE;
         S_SETTLE: if (r_settle == 16'(SETTLE_CYCLES - 1)) w_state_next = w_any ? S_SCAN : S_DRAIN;
         S_SCAN:   if (w_step && w_last) w_state_next = S_DRAIN;
         S_DRAIN:  if ((r_retired == r_issued) && !w_retire) w_state_next = S_DONE;
         S_DONE:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
      // Drain shifts stop once every issued window has a retirement scheduled.
      if (!i_hold) begin
         if (w_state_next == S_SCAN) begin
            w_en_next = 1'b1;
         end else if (w_state_next == S_DRAIN) begin
            w_en_next = (w_retired_next != w_issued_next);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_vj_enable  <= 1'b0;
         r_vj_reset   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_vj_enable  <= w_en_next;
         r_vj_reset   <= (w_state_next == S_CLEAR);
         r_busy       <= (w_state_next != S_IDLE);
         r_frame_done <= (w_state_next == S_DONE);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_settle      <= '0;
         r_issued      <= '0;
         r_retired     <= '0;
         r_fill        <= '0;
         r_retire_pend <= 1'b0;
         r_face_count  <= '0;
      end else begin
         r_retire_pend <= w_retire;
         r_settle      <= (r_state == S_SETTLE) ? r_settle + 16'd1 : 16'd0;
         if (w_accept) begin
            r_issued     <= '0;
            r_retired    <= '0;
            r_fill       <= '0;
            r_face_count <= '0;
         end else begin
            r_issued  <= w_issued_next;
            r_retired <= w_retired_next;
            if (r_vj_enable && !w_retire) begin
               r_fill <= r_fill + 32'd1;
            end
            if (o_face_valid && (r_face_count != 16'hFFFF)) begin
               r_face_count <= r_face_count + 16'd1;
            end
         end
      end
   end

   assign o_vj_enable  = r_vj_enable;
   assign o_vj_reset   = r_vj_reset;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;
   assign o_face_valid = r_retire_pend & i_face_coords_ready;
   assign o_face_count = r_face_count;

endmodule
`default_nettype wire

// File: tb/tb_scan_window_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scan_window_sequencer - directed vector table plus frame sequences    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_scan_window_sequencer;
   import scan_window_sequencer_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        start_a, hold_a, fcr_a;
   logic [3:0]  img_a;
   logic [31:0] row_a, col_a;
   logic        en_a, vrst_a, busy_a, done_a, fv_a;
   logic [15:0] fc_a;

   logic        start_b, hold_b, fcr_b;
   logic [3:0]  img_b;
   logic [31:0] row_b, col_b;
   logic        en_b, vrst_b, busy_b, done_b, fv_b;
   logic [15:0] fc_b;

   scan_window_sequencer #(
      .NUM_LEVELS    (2),
      .LEVEL_W       ({32'd26, 32'd25}),
      .LEVEL_H       ({32'd25, 32'd24}),
      .WIN           (24),
      .PIPE_DEPTH    (4),
      .SETTLE_CYCLES (2)
   ) dut_a (
      .clock(clock), .reset(reset), .i_start(start_a), .i_hold(hold_a),
      .i_face_coords_ready(fcr_a), .o_img_index(img_a), .o_row_index(row_a),
      .o_col_index(col_a), .o_vj_enable(en_a), .o_vj_reset(vrst_a), .o_busy(busy_a),
      .o_frame_done(done_a), .o_face_valid(fv_a), .o_face_count(fc_a)
   );

   // Level 0 is undersized and must be skipped; levels 1 and 2 use package geometry.
   scan_window_sequencer #(
      .NUM_LEVELS (3),
      .LEVEL_W    ({32'd20, 32'd35, 32'd51}),
      .LEVEL_H    ({32'd30, 32'd27, 32'd39})
   ) dut_b (
      .clock(clock), .reset(reset), .i_start(start_b), .i_hold(hold_b),
      .i_face_coords_ready(fcr_b), .o_img_index(img_b), .o_row_index(row_b),
      .o_col_index(col_b), .o_vj_enable(en_b), .o_vj_reset(vrst_b), .o_busy(busy_b),
      .o_frame_done(done_b), .o_face_valid(fv_b), .o_face_count(fc_b)
   );

   typedef struct {
      logic        start, hold, fcr;
      logic        en;
      logic [3:0]  img;
      logic [31:0] row, col;
      logic        vrst, busy, done, fv;
      logic [15:0] fc;
   } vec_t;

   localparam int NV = 19;
   vec_t        tv [NV];
   logic [67:0] exp_win [8];
   int          n_checks = 0;
   int          n_pass   = 0;

   wire [88:0] act_a = {en_a, img_a, row_a, col_a, vrst_a, busy_a, done_a, fv_a, fc_a};
   wire [88:0] act_b = {en_b, img_b, row_b, col_b, vrst_b, busy_b, done_b, fv_b, fc_b};

   function automatic vec_t mk(input int s, input int f, input int e, input int im,
                               input int r, input int c, input int vr, input int b,
                               input int d, input int fv, input int fc);
      vec_t v;
      v.start = 1'(s);  v.hold = 1'b0;  v.fcr  = 1'(f);
      v.en    = 1'(e);  v.img  = 4'(im); v.row = 32'(r); v.col = 32'(c);
      v.vrst  = 1'(vr); v.busy = 1'(b);  v.done = 1'(d); v.fv  = 1'(fv);
      v.fc    = 16'(fc);
      return v;
   endfunction

   function automatic logic [88:0] exp_pack(input vec_t v);
      return {v.en, v.img, v.row, v.col, v.vrst, v.busy, v.done, v.fv, v.fc};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // mode 0: plain frame; mode 1: hold bursts in SCAN and DRAIN plus a stray start;
   // mode 2: face_coords_ready toggling every cycle.
   task automatic run_frame(input int mode, output int n_win, output int n_drain,
                            output int n_fv, output int n_done, output int n_viol);
      logic prev_hold;
      n_win = 0; n_drain = 0; n_fv = 0; n_done = 0; n_viol = 0; prev_hold = 1'b0;
      for (int rel = 0; rel < 40; rel++) begin
         start_a = (rel == 0) || (mode == 1 && rel == 8);
         hold_a  = (mode == 1) && ((rel >= 6 && rel <= 8) || rel == 16 || rel == 17);
         fcr_a   = (mode == 2) ? rel[0] : 1'b1;
         #1;
         if (en_a && prev_hold) n_viol++;
         if (en_a) begin
            if (n_win < 8) begin
               check($sformatf("mode%0d window%0d", mode, n_win), {img_a, row_a, col_a}, exp_win[n_win]);
               n_win++;
            end else begin
               n_drain++;
            end
         end else if (busy_a && n_win > 0 && n_win < 8 && {img_a, row_a, col_a} != exp_win[n_win]) begin
            n_viol++;
         end
         if (fv_a)   n_fv++;
         if (done_a) n_done++;
         prev_hold = hold_a;
         @(negedge clock);
      end
      start_a = 1'b0;
      hold_a  = 1'b0;
      fcr_a   = 1'b1;
   endtask

   int nw, nd, nf, ndn, nv;
   int cnt0, cnt1, cnt2, fv_cnt_b;
   logic [3:0] first_img;
   logic       seen_first, seen_done;

   initial begin
      reset = 1'b1;
      start_a = 1'b0; hold_a = 1'b0; fcr_a = 1'b1;
      start_b = 1'b0; hold_b = 1'b0; fcr_b = 1'b1;

      exp_win[0] = {4'd0, 32'd0, 32'd0};
      exp_win[1] = {4'd0, 32'd0, 32'd1};
      exp_win[2] = {4'd0, 32'd0, 32'd2};
      exp_win[3] = {4'd0, 32'd1, 32'd0};
      exp_win[4] = {4'd0, 32'd1, 32'd1};
      exp_win[5] = {4'd0, 32'd1, 32'd2};
      exp_win[6] = {4'd1, 32'd0, 32'd0};
      exp_win[7] = {4'd1, 32'd0, 32'd1};

      // Cycle-by-cycle frame: start sampled at the end of row 0, stray start in row 6.
      tv[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tv[1]  = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      tv[2]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tv[3]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tv[4]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      tv[5]  = mk(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0);
      tv[6]  = mk(1, 1, 1, 0, 0, 2, 0, 1, 0, 0, 0);
      tv[7]  = mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 0);
      tv[8]  = mk(0, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0);
      tv[9]  = mk(0, 1, 1, 0, 1, 2, 0, 1, 0, 1, 0);
      tv[10] = mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 1);
      tv[11] = mk(0, 1, 1, 1, 0, 1, 0, 1, 0, 1, 2);
      tv[12] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 3);
      tv[13] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 4);
      tv[14] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 5);
      tv[15] = mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 6);
      tv[16] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 7);
      tv[17] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 8);
      tv[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8);

      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("reset state A", act_a, 89'd0);
      check("reset state B", act_b, 89'd0);
      @(negedge clock);

      for (int i = 0; i < NV; i++) begin
         start_a = tv[i].start;
         hold_a  = tv[i].hold;
         fcr_a   = tv[i].fcr;
         #1;
         check($sformatf("vector %0d", i), act_a, exp_pack(tv[i]));
         @(negedge clock);
      end

      run_frame(1, nw, nd, nf, ndn, nv);
      check("hold windows", nw, 8);
      check("hold drain shifts", nd, 4);
      check("hold face_valid pulses", nf, 8);
      check("hold frame_done pulses", ndn, 1);
      check("hold freeze violations", nv, 0);
      check("hold face_count", fc_a, 16'd8);

      run_frame(2, nw, nd, nf, ndn, nv);
      check("toggle face_valid pulses", nf, 4);
      check("toggle face_count", fc_a, 16'd4);
      check("toggle frame_done pulses", ndn, 1);

      for (int rel = 0; rel < 13; rel++) begin
         start_a = (rel == 0);
         fcr_a   = 1'b1;
         @(negedge clock);
      end
      #1;
      check("pre-reset drain activity", {en_a, busy_a, fv_a}, 3'b111);
      reset = 1'b1;
      #1;
      check("reset mid-drain", act_a, 89'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #1;
      check("idle after reset", act_a, 89'd0);
      @(negedge clock);

      run_frame(0, nw, nd, nf, ndn, nv);
      check("post-reset windows", nw, 8);
      check("post-reset drain shifts", nd, 4);
      check("post-reset face_valid pulses", nf, 8);
      check("post-reset frame_done pulses", ndn, 1);
      check("post-reset face_count", fc_a, 16'd8);

      cnt0 = 0; cnt1 = 0; cnt2 = 0; fv_cnt_b = 0;
      first_img = 4'hF; seen_first = 1'b0; seen_done = 1'b0;
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      for (int c = 0; c < 5000 && !seen_done; c++) begin
         #1;
         if (en_b) begin
            if (!seen_first) begin
               first_img  = img_b;
               seen_first = 1'b1;
            end
            if (img_b == 4'd0) cnt0++;
            if (img_b == 4'd1) cnt1++;
            if (img_b == 4'd2) cnt2++;
         end
         if (fv_b) fv_cnt_b++;
         if (done_b) begin
            seen_done = 1'b1;
            check("pyramid face_count", fc_b, 16'd496);
         end
         @(negedge clock);
      end
      check("pyramid frame_done seen", seen_done, 1'b1);
      check("pyramid first level", first_img, 4'd1);
      check("pyramid level1 windows", cnt1, 48);
      check("pyramid level2 windows", cnt2, 448);
      check("pyramid drain shifts", cnt0, 2914);
      check("pyramid face_valid pulses", fv_cnt_b, 496);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scan_window_sequencer.md
# scan_window_sequencer

Sequencing FSM for the Viola-Jones detection path. It starts on an incoming frame and clears `vj_pipeline`. After the downscaler and integral-image logic settle, it raster-scans a 24x24 window across every pyramid level by driving `img_index`, `row_index` and `col_index`. It gates `vj_pipeline` shifting with `vj_enable`, drains the pipeline, and marks which `face_coords_ready` pulses are genuine detections. It sits in `top` between the frame-ready input and `vj_pipeline`.

## Interface
Parameters:
- `NUM_LEVELS`, 13: pyramid levels scanned, index 0 first.
- `LEVEL_W`, `vj_pkg::PYRAMID_WIDTHS`: per-level valid width, 13 x 32 b.
- `LEVEL_H`, `vj_pkg::PYRAMID_HEIGHTS`: per-level valid height, 13 x 32 b.
- `WIN`, 24: window edge in pixels.
- `PIPE_DEPTH`, 2914: enabled shifts from injection to `face_coords_ready` validity.
- `SETTLE_CYCLES`, 4: wait after frame load before the first window.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: frame-ready pulse (`laptop_img_rdy`).
- `hold`, in, 1: downstream backpressure; freezes scanning and shifting.
- `face_coords_ready`, in, 1: from `vj_pipeline`.
- `img_index`, out, 4: current pyramid level.
- `row_index`, out, 32: window top row.
- `col_index`, out, 32: window left column.
- `vj_enable`, out, 1: pipeline shift enable.
- `vj_reset`, out, 1: pipeline clear, one-cycle pulse.
- `busy`, out, 1: high in every state except IDLE.
- `frame_done`, out, 1: one-cycle pulse at end of frame.
- `face_valid`, out, 1: qualified detection, one cycle per detection.
- `face_count`, out, 16: detections this frame, saturating.

## Operation
- Reset values: every output is 0; state is IDLE.
- States: IDLE -> CLEAR -> SETTLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - `start`=1 -> CLEAR.
  - Clears `face_count`, the `issued` counter and the `retired` counter.
- CLEAR: `vj_reset`=1 for exactly one cycle, then SETTLE.
- SETTLE: counts `SETTLE_CYCLES` cycles regardless of `hold`, then SCAN.
- SCAN: when `hold`=0, `vj_enable`=1, the window at (`img_index`, `row_index`, `col_index`) is injected, and `issued` increments. Indices then advance:
  - `col_index`++ while `col_index` < `LEVEL_W[l]`-`WIN`.
  - Otherwise `col_index`=0 and `row_index`++ while `row_index` < `LEVEL_H[l]`-`WIN`.
  - Otherwise both are 0 and `img_index`++.
  - After the last window of level `NUM_LEVELS`-1, go to DRAIN. Indices return to 0.
  - When `hold`=1, `vj_enable`=0 and all indices and counters hold.
- Fill counter: counts enabled shifts and saturates at `PIPE_DEPTH`. Once saturated, every further enabled shift retires one window: `retired`++ and `retire_pend` is set for one cycle.
- DRAIN: `vj_enable`=!`hold`; indices stay at 0. Leave for DONE when `retired` == `issued` and `retire_pend`=0.
- DONE: `frame_done`=1 for one cycle, then IDLE. `face_count` holds until the next start.
- `face_valid` = `retire_pend` & `face_coords_ready`.
  - Each window reports exactly once, even under `hold`.
  - `face_count` increments on `face_valid` and saturates at 0xFFFF.
- `start` while `busy`=1 is ignored, not queued.
- `reset` mid-frame returns immediately to IDLE with reset output values. The pipeline is cleared by the next CLEAR.
- Level with `LEVEL_W` < `WIN` or `LEVEL_H` < `WIN`: skipped, no windows issued.

## Timing
- First window appears `1 + SETTLE_CYCLES` cycles after the edge that samples `start`, with `hold`=0.
- One window per unheld cycle; there are no bubbles at row or level wraps.
- A window injected on enabled edge k is reported in the cycle after enabled edge k+`PIPE_DEPTH`.
- `frame_done` follows the final `retire_pend` cycle by one cycle.
- All outputs are registered except `face_valid` (AND of register and input).

## Structure
- `vj_pkg` holds:
  - `PYRAMID_WIDTHS` = {320,266,222,185,154,128,107,89,74,62,51,43,35}
  - `PYRAMID_HEIGHTS` = {240,200,166,139,116,96,80,67,56,46,39,32,27}
  - `WIN_SIZE`=24
  - `VJ_PIPE_DEPTH`=2914
  - state enum `seq_state_t`
- One sub-module, `window_raster_counter`, implements the col/row/level nested counter with wrap and `last` flag. The FSM, fill/issue/retire counters and face qualification stay in the top module.

## Test plan
Bench config unless stated: `NUM_LEVELS`=2, `LEVEL_W`={26,25}, `LEVEL_H`={25,24}, `PIPE_DEPTH`=4, `SETTLE_CYCLES`=2.
- Raster order: `start` pulse -> `vj_reset` once; after 2 cycles, 8 enabled windows:
  - level 0: (0,0,0)..(0,0,2), (0,1,0)..(0,1,2)
  - level 1: (1,0,0), (1,0,1)
  - then `frame_done` after 4 drain shifts.
- Detection qualification: `face_coords_ready` held 1 throughout -> exactly 8 `face_valid` pulses and `face_count`=8. None before the 5th enabled edge.
- Backpressure: `hold`=1 for 3 cycles mid-SCAN and 2 in DRAIN -> indices freeze, no duplicate `face_valid`, total still 8.
- `start` re-pulsed during SCAN -> ignored, sequence unchanged. `reset` asserted mid-DRAIN -> all outputs 0 immediately, state IDLE.
- Default package config -> 64449 level-0 windows, level 12 issues 12x4=48, and `frame_done` fires after `issued`==`retired`.
